// File: rtl/sd_pkg.sv
// Shared types for the SD block sequencer: FSM states, byte-mux selects,
// the start token and the state-to-output decode used by the output register.
package sd_pkg;

  localparam logic [7:0] START_TOKEN = 8'hFE;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LD_TOK = 4'd1,
    WT_TOK = 4'd2,
    LD_DAT = 4'd3,
    WT_DAT = 4'd4,
    LD_CHI = 4'd5,
    WT_CHI = 4'd6,
    LD_CLO = 4'd7,
    WT_CLO = 4'd8,
    DONE   = 4'd9,
    ERR    = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    SEL_TOKEN  = 2'd0,
    SEL_DATA   = 2'd1,
    SEL_CRC_HI = 2'd2,
    SEL_CRC_LO = 2'd3
  } sel_t;

  typedef struct packed {
    logic busy;
    logic load_byte;
    logic fifo_rd;
    sel_t sel;
    logic done;
    logic underrun;
  } outs_t;

  // The WT_* states keep sel on the byte in flight so the mux stays steady.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o      = '0;
    o.busy = (s != IDLE);
    case (s)
      LD_TOK: begin o.load_byte = 1'b1; o.sel = SEL_TOKEN; end
      WT_TOK: o.sel = SEL_TOKEN;
      LD_DAT: begin o.load_byte = 1'b1; o.fifo_rd = 1'b1; o.sel = SEL_DATA; end
      WT_DAT: o.sel = SEL_DATA;
      LD_CHI: begin o.load_byte = 1'b1; o.sel = SEL_CRC_HI; end
      WT_CHI: o.sel = SEL_CRC_HI;
      LD_CLO: begin o.load_byte = 1'b1; o.sel = SEL_CRC_LO; end
      WT_CLO: o.sel = SEL_CRC_LO;
      DONE:   o.done = 1'b1;
      ERR:    o.underrun = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps from rollover_val back to 1; rollover_flag
// is registered and high while the count equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] next_count;

  // NOTE: give every combinational output a default first so no path leaves it unassigned (latch).
  always_comb begin
    next_count = count_out;
    if (clear)
      next_count = '0;
    else if (count_enable)
      next_count = (count_out == rollover_val) ? NUM_CNT_BITS'(1)
                                                : count_out + NUM_CNT_BITS'(1);
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= (next_count == rollover_val);
    end
  end

endmodule

// File: rtl/sd_block_sequencer.sv
// Sequences one SD data block (start token, BLOCK_BYTES FIFO bytes, CRC high/low)
// into a byte shifter, with abort and FIFO-underrun handling.
module sd_block_sequencer
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES = 512
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       abort,
  input  logic       byte_done,
  input  logic       fifo_empty,
  output logic       load_byte,
  output logic [1:0] sel,
  output logic       fifo_rd,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic [9:0] byte_cnt
);

  state_t state, next_state;
  outs_t  out_d, out_q;
  logic   start_accept;
  logic   last_byte;

  assign start_accept = (state == IDLE) && start && !abort;

  flex_counter #(
    .NUM_CNT_BITS (10)
  ) u_byte_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (start_accept),
    .count_enable  (state == LD_DAT),
    .rollover_val  (10'(BLOCK_BYTES)),
    .count_out     (byte_cnt),
    .rollover_flag (last_byte)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Abort wins over everything, including a byte_done in the same cycle.
  always_comb begin
    next_state = state;
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_accept) next_state = LD_TOK;
        LD_TOK:  next_state = WT_TOK;
        WT_TOK:  if (byte_done) next_state = fifo_empty ? ERR : LD_DAT;
        LD_DAT:  next_state = WT_DAT;
        WT_DAT:  if (byte_done) next_state = last_byte  ? LD_CHI :
                                             fifo_empty ? ERR    : LD_DAT;
        LD_CHI:  next_state = WT_CHI;
        WT_CHI:  if (byte_done) next_state = LD_CLO;
        LD_CLO:  next_state = WT_CLO;
        WT_CLO:  if (byte_done) next_state = DONE;
        DONE:    next_state = IDLE;
        ERR:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Decoding next_state into a register makes each output a flop that
  // tracks the current state exactly, with no decode glitches.
  always_comb begin
    out_d = decode(next_state);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) out_q <= '0;
    else        out_q <= out_d;
  end

  assign busy      = out_q.busy;
  assign load_byte = out_q.load_byte;
  assign fifo_rd   = out_q.fifo_rd;
  assign sel       = out_q.sel;
  assign done      = out_q.done;
  assign underrun  = out_q.underrun;

endmodule
